range_bn_engine: RTL
====================

# range_bn_engine

Multi-channel range batch-normalization engine, the next-generation BN stage behind the systolic array. It takes CH parallel channel results per beat and buffers a mini-batch per channel. Batch mean and power-of-two range are computed per channel, then y = gamma·(x−mean)/2^shift + beta is streamed out under ready/valid backpressure. It adds an inference mode that uses momentum-updated running statistics with no buffering.

## Interface
- CH, 4, parallel channels (one lane each)
- DATA_WIDTH, 16, signed fixed-point sample/gamma/beta width
- FRAC_BITS, 8, fractional bits of gamma (1.0 = 2^FRAC_BITS)
- MINI_BATCH, 8, samples per batch; power of two ≥ 2
- MOM_SHIFT, 3, running-mean momentum = 2^-MOM_SHIFT
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- mode_in  in  1  0 = TRAIN (batch stats), 1 = INFER (running stats); sampled only in IDLE
- gamma_in  in  CH·DATA_WIDTH  per-channel scale
- beta_in  in  CH·DATA_WIDTH  per-channel shift
- param_valid  in  1  loads gamma/beta when state is IDLE or COLLECT; ignored otherwise
- x_in  in  CH·DATA_WIDTH  channel samples, lane c at bits [c·DW +: DW]
- x_valid / x_ready  in/out  1  input handshake; beat accepted when both high
- y_out  out  CH·DATA_WIDTH  normalized outputs, registered
- y_valid / y_ready  out/in  1  output handshake
- busy  out  1  high in COLLECT, COMPUTE, DRAIN

## Operation
- States: IDLE, COLLECT, COMPUTE, DRAIN.
- IDLE, mode_in=0: the first accepted beat latches TRAIN, is written to buffer[0], and moves to COLLECT.
- IDLE, mode_in=1: INFER streaming, staying in IDLE. y = f(x, run_mean, run_shift).
- COLLECT: one beat per accepted cycle is written at wr_ptr. Per lane, sum (DW+log2 MB bits), min and max are updated. The accept of beat MINI_BATCH−1 moves to COMPUTE.
- COMPUTE (1 cycle):
  - mean = sum >>> log2(MINI_BATCH).
  - range = max − min, unsigned DW bits.
  - shift = floor(log2 range), or 0 when range = 0.
  - run_mean += (mean − run_mean) >>> MOM_SHIFT.
  - run_shift = shift.
  - Then go to DRAIN with rd_ptr = 0.
- DRAIN: y = ((x−mean)·gamma) >>> shift + beta for buffer[rd_ptr]. rd_ptr advances when the output register is free. After MINI_BATCH outputs are accepted, return to IDLE.
- Arithmetic: diff is DW+1 bits; the product is 2·DW+1 bits; the arithmetic shift comes before the beta add; the final sum is DW+2 bits, reduced per Configuration.
- Constant batch (range = 0): every y = beta.
- x_ready: 1 in COLLECT; 0 in COMPUTE and DRAIN; in IDLE/INFER it is (!y_valid || y_ready).
- param_valid in the same cycle as an accepted beat: new gamma/beta apply to the next DRAIN or INFER computation.
- rst anywhere (including mid-DRAIN) discards buffer contents and returns to IDLE.
- Reset values:
  - y_out = 0, y_valid = 0, x_ready = 0 during rst and 1 the cycle after, busy = 0.
  - run_mean = 0, run_shift = 0, gamma = 1<<FRAC_BITS, beta = 0, pointers and accumulators 0.

## Timing
- TRAIN: first y_valid 2 cycles after the last input beat is accepted (COMPUTE, then output register). With y_ready held high, MINI_BATCH outputs come on consecutive cycles.
- INFER: y_valid 1 cycle after x accepted; full throughput with y_ready = 1.
- y_valid=1 with y_ready=0: y_out stays stable and rd_ptr is held.
- Minimum period per TRAIN batch: 2·MINI_BATCH + 1 cycles.

## Configuration
- RANGE_BN_SAT_EN defined: the final sum saturates to [−2^(DW−1), 2^(DW−1)−1].
- RANGE_BN_SAT_EN undefined: the final sum is truncated to its low DW bits (two's-complement wrap).

## Structure
- range_bn_pkg holds:
  - state enum (IDLE/COLLECT/COMPUTE/DRAIN)
  - mode constants MODE_TRAIN = 0, MODE_INFER = 1
  - the floor-log2 priority-encoder function
  - the saturate/truncate function
- Sub-module range_bn_lane (per-channel stats, gamma/beta regs, running stats, output datapath) is instantiated CH times. The top holds the FSM, pointers, the shared MINI_BATCH×CH·DW buffer and the handshakes.

## Test plan
Lane 0 values below use FRAC_BITS = 8 and MINI_BATCH = 8.
- TRAIN ramp: x = 0,256,…,1792, gamma = 256, beta = 0 → mean 896, shift 10; y = −224, −160, −96, −32, 32, 96, 160, 224.
- Constant batch: all x = 512, beta = 128 → range 0; all eight y = 128.
- Saturation: x = {0×7, 256}, gamma = 0x7FFF, beta = 0x4000 → last y = 32767 with RANGE_BN_SAT_EN, −20481 without.
- INFER after the ramp batch: run_mean = 112, run_shift = 10; x = 1136, gamma = 256 → y = 256 one cycle later.
- Backpressure: y_ready low for 5 cycles mid-DRAIN → y_out is stable, x_ready stays 0, no output is lost or duplicated.
- rst asserted after 3 DRAIN outputs → next cycle y_valid = 0 and busy = 0. A fresh ramp batch then reproduces the first scenario exactly.

Source files
------------

// File: rtl/range_bn_pkg.sv
// Shared types and helpers for the range batch-normalization engine.
// Optional build macro: RANGE_BN_SAT_EN selects saturation of the final
// output sum; without it the sum wraps to DATA_WIDTH bits.
package range_bn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam logic MODE_TRAIN = 1'b0;
  localparam logic MODE_INFER = 1'b1;

  // Index of the highest set bit; 0 for a zero input.
  function automatic logic [4:0] floor_log2(input logic [31:0] v);
    logic [4:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

  // Reduce a signed value to dw bits: clamp, or sign-extend from bit dw-1.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] v,
                                                   input int unsigned dw);
`ifdef RANGE_BN_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
`else
    return (v <<< (64 - dw)) >>> (64 - dw);
`endif
  endfunction

endpackage

// File: rtl/range_bn_lane.sv
// One channel of the BN engine: batch statistics, gamma/beta registers,
// running statistics and the registered normalization datapath.
module range_bn_lane
  import range_bn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned MINI_BATCH = 8,
  parameter int unsigned MOM_SHIFT  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stat_init,
  input  logic                         stat_acc,
  input  logic                         compute,
  input  logic                         param_load,
  input  logic                         use_run,
  input  logic                         y_load,
  input  logic signed [DATA_WIDTH-1:0] x_stat,
  input  logic signed [DATA_WIDTH-1:0] x_norm,
  input  logic signed [DATA_WIDTH-1:0] gamma_set,
  input  logic signed [DATA_WIDTH-1:0] beta_set,
  output logic signed [DATA_WIDTH-1:0] y
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned LB = $clog2(MINI_BATCH);
  localparam int unsigned SW = DW + LB;

  logic signed [SW-1:0]   sum;
  logic signed [SW-1:0]   x_ext;
  logic signed [DW-1:0]   mn, mx, mean, run_mean, gamma, beta;
  logic signed [DW-1:0]   mean_c, m_sel, y_nxt;
  logic        [DW-1:0]   rng;
  logic        [4:0]      run_shift, shift_c;
  logic signed [DW:0]     mom, diff;
  logic signed [2*DW:0]   prod;
  logic signed [DW+1:0]   fin;

  assign x_ext = {{LB{x_stat[DW-1]}}, x_stat};

  // Per-batch sum/min/max, seeded by the first beat of the batch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      mn  <= '0;
      mx  <= '0;
    end else if (stat_init) begin
      sum <= x_ext;
      mn  <= x_stat;
      mx  <= x_stat;
    end else if (stat_acc) begin
      sum <= sum + x_ext;
      if (x_stat < mn) mn <= x_stat;
      if (x_stat > mx) mx <= x_stat;
    end
  end

  // Batch mean, power-of-two range and momentum step toward the new mean.
  always_comb begin
    mean_c  = DW'(sum >>> LB);
    rng     = DW'({mx[DW-1], mx} - {mn[DW-1], mn});
    shift_c = floor_log2(32'(rng));
    mom     = {mean_c[DW-1], mean_c} - {run_mean[DW-1], run_mean};
  end

  // Statistics registers updated in the single COMPUTE cycle; the shift is
  // shared by DRAIN and INFER since run_shift always equals the last batch shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      mean      <= '0;
      run_mean  <= '0;
      run_shift <= '0;
    end else if (compute) begin
      mean      <= mean_c;
      run_mean  <= run_mean + DW'(mom >>> MOM_SHIFT);
      run_shift <= shift_c;
    end
  end

  // Scale/shift parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      gamma <= DW'(1 << FRAC_BITS);
      beta  <= '0;
    end else if (param_load) begin
      gamma <= gamma_set;
      beta  <= beta_set;
    end
  end

  // y = ((x - mean) * gamma) >>> shift + beta, reduced to DW bits.
  always_comb begin
    m_sel = use_run ? run_mean : mean;
    diff  = {x_norm[DW-1], x_norm} - {m_sel[DW-1], m_sel};
    prod  = diff * gamma;
    fin   = (DW + 2)'(prod >>> run_shift) + {{2{beta[DW-1]}}, beta};
    y_nxt = DW'(sat_trunc({{(64 - DW - 2){fin[DW+1]}}, fin}, DW));
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) y <= '0;
    else if (y_load) y <= y_nxt;
  end

endmodule

// File: rtl/range_bn_engine.sv
// Multi-channel range batch-normalization engine: buffers a mini-batch,
// computes per-channel mean and power-of-two range, then streams normalized
// outputs; INFER mode streams directly using running statistics.
// Optional build macro: RANGE_BN_SAT_EN (saturating output instead of wrap).
module range_bn_engine
  import range_bn_pkg::*;
#(
  parameter int unsigned CH         = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned MINI_BATCH = 8,
  parameter int unsigned MOM_SHIFT  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode_in,
  input  logic [CH*DATA_WIDTH-1:0]   gamma_in,
  input  logic [CH*DATA_WIDTH-1:0]   beta_in,
  input  logic                       param_valid,
  input  logic [CH*DATA_WIDTH-1:0]   x_in,
  input  logic                       x_valid,
  output logic                       x_ready,
  output logic [CH*DATA_WIDTH-1:0]   y_out,
  output logic                       y_valid,
  input  logic                       y_ready,
  output logic                       busy
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned LB = $clog2(MINI_BATCH);

  state_t                state, state_nxt;
  logic [LB-1:0]         wr_ptr, rd_ptr;
  logic [CH*DW-1:0]      buffer [MINI_BATCH];
  logic [CH*DW-1:0]      drain_word;
  logic                  out_free;
  logic                  stat_init, stat_acc, compute, infer_load, drain_load;
  logic                  param_load, y_load, in_drain;

  assign out_free   = !y_valid || y_ready;
  assign param_load = param_valid && (state == IDLE || state == COLLECT);
  assign y_load     = drain_load || infer_load;
  assign in_drain   = (state == DRAIN);
  assign drain_word = buffer[rd_ptr];

  // Next-state, handshake and datapath strobes.
  // DRAIN hands back to IDLE as soon as the last word is loaded: the IDLE
  // ready term already waits on the output register, so the last output's
  // accept can overlap the first beat of the next batch.
  always_comb begin
    state_nxt  = state;
    x_ready    = 1'b0;
    busy       = 1'b0;
    stat_init  = 1'b0;
    stat_acc   = 1'b0;
    compute    = 1'b0;
    infer_load = 1'b0;
    drain_load = 1'b0;
    case (state)
      IDLE: begin
        x_ready = out_free;
        if (x_valid && out_free) begin
          if (mode_in == MODE_TRAIN) begin
            stat_init = 1'b1;
            state_nxt = COLLECT;
          end else begin
            infer_load = 1'b1;
          end
        end
      end
      COLLECT: begin
        busy    = 1'b1;
        x_ready = 1'b1;
        if (x_valid) begin
          stat_acc = 1'b1;
          if (wr_ptr == LB'(MINI_BATCH - 1)) state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        busy      = 1'b1;
        compute   = 1'b1;
        state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_free) begin
          drain_load = 1'b1;
          if (rd_ptr == LB'(MINI_BATCH - 1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) x_ready = 1'b0;
  end

  // State, pointers and output-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      y_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (stat_init) wr_ptr <= LB'(1);
      else if (stat_acc) wr_ptr <= wr_ptr + 1'b1;
      if (compute) rd_ptr <= '0;
      else if (drain_load) rd_ptr <= rd_ptr + 1'b1;
      if (y_load) y_valid <= 1'b1;
      else if (y_ready) y_valid <= 1'b0;
    end
  end

  // Mini-batch sample buffer; contents are meaningless after reset.
  always_ff @(posedge clk) begin
    if (stat_init) buffer[0] <= x_in;
    else if (stat_acc) buffer[wr_ptr] <= x_in;
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    range_bn_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .MINI_BATCH(MINI_BATCH),
      .MOM_SHIFT (MOM_SHIFT)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .stat_init (stat_init),
      .stat_acc  (stat_acc),
      .compute   (compute),
      .param_load(param_load),
      .use_run   (!in_drain),
      .y_load    (y_load),
      .x_stat    (x_in[c*DW +: DW]),
      .x_norm    (in_drain ? drain_word[c*DW +: DW] : x_in[c*DW +: DW]),
      .gamma_set (gamma_in[c*DW +: DW]),
      .beta_set  (beta_in[c*DW +: DW]),
      .y         (y_out[c*DW +: DW])
    );
  end

endmodule
